stopwatch_core: RTL

MM:SS stopwatch counter that consumes the divider's slow clock outputs (incClk 1 Hz, adjClk 2 Hz) as level signals in the masterClk domain. It converts their rising edges into single-cycle ticks and keeps four BCD digits. Run/pause and adjust modes are handled here. The digit outputs feed the display multiplexer that runs on fastClk/blinkClk.

---
 rtl/stopwatch_pkg.sv | 28 ++
 rtl/sw_bcd_field.sv | 49 ++++
 rtl/stopwatch_core.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PAUSED = 2'd1,
    ST_ADJUST = 2'd2
  } state_t;

  typedef logic [3:0] bcd_t;

  // adjField encodings, consumed by the display blinker
  localparam logic [1:0] ADJ_NONE = 2'b00;
  localparam logic [1:0] ADJ_MIN  = 2'b01;
  localparam logic [1:0] ADJ_SEC  = 2'b10;

  localparam int DEF_MAX_MIN = 99;
  localparam int DEF_MAX_SEC = 59;

  function automatic bcd_t tens_of(input int value);
    return bcd_t'(value / 10);
  endfunction

  function automatic bcd_t ones_of(input int value);
    return bcd_t'(value % 10);
  endfunction

endpackage

// File: rtl/sw_bcd_field.sv
// Two-digit BCD counter that wraps from LIMIT back to 00.
// carry flags an increment that happens while the field sits at LIMIT.
module sw_bcd_field
  import stopwatch_pkg::*;
#(
  parameter int LIMIT = 59
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output bcd_t tens,
  output bcd_t ones,
  output logic carry
);

  localparam bcd_t LIM_TENS = tens_of(LIMIT);
  localparam bcd_t LIM_ONES = ones_of(LIMIT);

  logic at_limit;

  // limit detect and carry out toward the next field
  always_comb begin
    at_limit = (tens == LIM_TENS) && (ones == LIM_ONES);
    carry    = inc && at_limit;
  end

  // digit registers: clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens <= '0;
      ones <= '0;
    end else if (clr) begin
      tens <= '0;
      ones <= '0;
    end else if (inc) begin
      if (at_limit) begin
        tens <= '0;
        ones <= '0;
      end else if (ones == 4'd9) begin
        ones <= '0;
        tens <= tens + 4'd1;
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_core.sv
// MM:SS stopwatch core: tick detection, run/pause/adjust FSM, BCD digits.
// Optional lap hold is enabled with the STOPWATCH_LAP_EN macro.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_RUN    | counting seconds on each incClk rising edge
// ST_PAUSED | digits frozen, waiting for pauseBtn
// ST_ADJUST | adjClk edges step the field chosen by selSw, no carry
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int MAX_MIN = DEF_MAX_MIN,
  parameter int MAX_SEC = DEF_MAX_SEC
) (
  input  logic       masterClk,
  input  logic       rst,
  input  logic       incClk,
  input  logic       adjClk,
  input  logic       pauseBtn,
  input  logic       clrBtn,
  input  logic       adjSw,
  input  logic       selSw,
`ifdef STOPWATCH_LAP_EN
  input  logic       lapBtn,
`endif
  output bcd_t       minTens,
  output bcd_t       minOnes,
  output bcd_t       secTens,
  output bcd_t       secOnes,
  output logic       running,
  output logic [1:0] adjField
);

  state_t state, next_state;
  state_t ret_state, ret_next;

  logic inc_q, adj_q;
  logic inc_tick, adj_tick;
  logic run_tick, adj_step;
  logic sec_inc, min_inc;
  logic sec_carry, min_wrap_unused;
  logic enter_adjust;

  bcd_t live_min_t, live_min_o, live_sec_t, live_sec_o;

  // delayed copies of the divider outputs for rising-edge detection
  always_ff @(posedge masterClk or negedge rst) begin
    if (!rst) begin
      inc_q <= 1'b0;
      adj_q <= 1'b0;
    end else begin
      inc_q <= incClk;
      adj_q <= adjClk;
    end
  end

  // tick decode; a tick arriving with adjSw already high is dropped
  always_comb begin
    inc_tick     = incClk & ~inc_q;
    adj_tick     = adjClk & ~adj_q;
    run_tick     = (state == ST_RUN) && !adjSw && inc_tick;
    adj_step     = (state == ST_ADJUST) && adj_tick;
    enter_adjust = (state != ST_ADJUST) && adjSw;
    sec_inc      = run_tick || (adj_step && selSw);
    min_inc      = (run_tick && sec_carry) || (adj_step && !selSw);
  end

  // state register plus the state to return to after adjust
  always_ff @(posedge masterClk or negedge rst) begin
    if (!rst) begin
      state     <= ST_RUN;
      ret_state <= ST_RUN;
    end else begin
      state     <= next_state;
      ret_state <= ret_next;
    end
  end

  // next-state and status outputs
  always_comb begin
    next_state = state;
    ret_next   = ret_state;
    running    = (state == ST_RUN);
    adjField   = ADJ_NONE;
    case (state)
      ST_RUN, ST_PAUSED: begin
        if (adjSw) begin
          next_state = ST_ADJUST;
          ret_next   = state;
        end else if (pauseBtn) begin
          next_state = (state == ST_RUN) ? ST_PAUSED : ST_RUN;
        end
      end
      ST_ADJUST: begin
        adjField = selSw ? ADJ_SEC : ADJ_MIN;
        if (!adjSw) next_state = ret_state;
      end
      default: next_state = ST_RUN;
    endcase
  end

  sw_bcd_field #(.LIMIT(MAX_SEC)) u_sec (
    .clk   (masterClk),
    .rst_n (rst),
    .inc   (sec_inc),
    .clr   (clrBtn),
    .tens  (live_sec_t),
    .ones  (live_sec_o),
    .carry (sec_carry)
  );

  // minute rollover past MAX_MIN simply wraps; nothing downstream needs it
  sw_bcd_field #(.LIMIT(MAX_MIN)) u_min (
    .clk   (masterClk),
    .rst_n (rst),
    .inc   (min_inc),
    .clr   (clrBtn),
    .tens  (live_min_t),
    .ones  (live_min_o),
    .carry (min_wrap_unused)
  );

`ifdef STOPWATCH_LAP_EN
  logic        lap_active;
  logic [15:0] lap_digits;

  // lap hold: toggled by lapBtn in RUN, dropped on clear or adjust entry
  always_ff @(posedge masterClk or negedge rst) begin
    if (!rst) begin
      lap_active <= 1'b0;
      lap_digits <= '0;
    end else if (clrBtn || enter_adjust) begin
      lap_active <= 1'b0;
    end else if ((state == ST_RUN) && lapBtn) begin
      lap_active <= ~lap_active;
      if (!lap_active) lap_digits <= {live_min_t, live_min_o, live_sec_t, live_sec_o};
    end
  end

  assign {minTens, minOnes, secTens, secOnes} = lap_active ? lap_digits
         : {live_min_t, live_min_o, live_sec_t, live_sec_o};
`else
  logic enter_adjust_unused;
  assign enter_adjust_unused = enter_adjust;
  assign {minTens, minOnes, secTens, secOnes} = {live_min_t, live_min_o, live_sec_t, live_sec_o};
`endif

endmodule
